// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard controller (slave).
interface pipe_hazard_ctrl_if;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_use_rs;
    logic        id_use_rt;
    logic [4:0]  exe_wbdst;
    logic        exe_regw;
    logic        exe_regw_src;
    logic        exe_stopnext;
    logic [4:0]  mem_wbdst;
    logic        mem_regw;
    logic        mem_wait;
    logic        pc_en;
    logic        ifid_en;
    logic        ifid_flush;
    logic        idexe_en;
    logic        idexe_flush;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [1:0]  state;
    logic [15:0] stall_cnt;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt,
               exe_wbdst, exe_regw, exe_regw_src, exe_stopnext,
               mem_wbdst, mem_regw, mem_wait,
        input  pc_en, ifid_en, ifid_flush, idexe_en, idexe_flush,
               fwd_a, fwd_b, state, stall_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt,
               exe_wbdst, exe_regw, exe_regw_src, exe_stopnext,
               mem_wbdst, mem_regw, mem_wait,
        output pc_en, ifid_en, ifid_flush, idexe_en, idexe_flush,
               fwd_a, fwd_b, state, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline hazard controller: forwarding select, stall/flush control, stall counter.
// Optional macro PIPE_FWD_EN enables EXE/MEM bypass; otherwise every RAW hazard bubbles.
module pipe_hazard_ctrl (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        RUN   = 2'b00,
        LDUSE = 2'b01,
        FLUSH = 2'b10,
        WAIT  = 2'b11
    } hz_state_e;

    hz_state_e   state_q, state_d;
    logic        pend_q, pend_d;
    logic [15:0] cnt_q;

    logic rs_hit_e, rt_hit_e, rs_hit_m, rt_hit_m;
    logic load_use, hazard;
    logic pc_en_c, ifid_en_c, ifid_flush_c, idexe_en_c, idexe_flush_c;
    logic [1:0] fwd_a_c, fwd_b_c;

    assign rs_hit_e = hz.exe_regw && (hz.exe_wbdst != '0) && (hz.exe_wbdst == hz.id_rs);
    assign rt_hit_e = hz.exe_regw && (hz.exe_wbdst != '0) && (hz.exe_wbdst == hz.id_rt);
    assign rs_hit_m = hz.mem_regw && (hz.mem_wbdst != '0) && (hz.mem_wbdst == hz.id_rs);
    assign rt_hit_m = hz.mem_regw && (hz.mem_wbdst != '0) && (hz.mem_wbdst == hz.id_rt);

    assign load_use = hz.exe_regw_src &&
                      ((hz.id_use_rs && rs_hit_e) || (hz.id_use_rt && rt_hit_e));

`ifdef PIPE_FWD_EN
    assign hazard  = load_use;
    assign fwd_a_c = (rs_hit_e && !hz.exe_regw_src) ? 2'b01 :
                     rs_hit_m                       ? 2'b10 : 2'b00;
    assign fwd_b_c = (rt_hit_e && !hz.exe_regw_src) ? 2'b01 :
                     rt_hit_m                       ? 2'b10 : 2'b00;
`else
    // No bypass: non-load EXE hits and MEM hits stall as well, in addition to load-use.
    assign hazard  = load_use ||
                     (hz.id_use_rs && ((rs_hit_e && !hz.exe_regw_src) || rs_hit_m)) ||
                     (hz.id_use_rt && ((rt_hit_e && !hz.exe_regw_src) || rt_hit_m));
    assign fwd_a_c = '0;
    assign fwd_b_c = '0;
`endif

    always_comb begin
        state_d       = RUN;
        pend_d        = 1'b0;
        pc_en_c       = 1'b1;
        ifid_en_c     = 1'b1;
        ifid_flush_c  = 1'b0;
        idexe_en_c    = 1'b1;
        idexe_flush_c = 1'b0;

        // A redirect seen while frozen is held and replayed once memory releases.
        if (hz.mem_wait) begin
            state_d = WAIT;
            pend_d  = pend_q | hz.exe_stopnext;
        end else if (hz.exe_stopnext || pend_q) begin
            state_d = FLUSH;
        end else if (hazard) begin
            state_d = LDUSE;
        end

        unique case (state_d)
            RUN: ;
            LDUSE: begin
                pc_en_c       = 1'b0;
                ifid_en_c     = 1'b0;
                idexe_flush_c = 1'b1;
            end
            FLUSH: begin
                ifid_flush_c  = 1'b1;
                idexe_flush_c = 1'b1;
            end
            WAIT: begin
                pc_en_c    = 1'b0;
                ifid_en_c  = 1'b0;
                idexe_en_c = 1'b0;
            end
        endcase

        if (!rst) begin
            pc_en_c       = 1'b1;
            ifid_en_c     = 1'b1;
            ifid_flush_c  = 1'b0;
            idexe_en_c    = 1'b1;
            idexe_flush_c = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            pend_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            if (!pc_en_c && (cnt_q != '1))
                cnt_q <= cnt_q + 16'd1;
        end
    end

    assign hz.pc_en       = pc_en_c;
    assign hz.ifid_en     = ifid_en_c;
    assign hz.ifid_flush  = ifid_flush_c;
    assign hz.idexe_en    = idexe_en_c;
    assign hz.idexe_flush = idexe_flush_c;
    assign hz.fwd_a       = rst ? fwd_a_c : 2'b00;
    assign hz.fwd_b       = rst ? fwd_b_c : 2'b00;
    assign hz.state       = state_q;
    assign hz.stall_cnt   = cnt_q;
endmodule
